// File: rtl/hdmi_pix_fetch.sv
// Frame reader: prefetches one frame of pixels from memory read port 0 into a
// small FIFO and streams one pixel per active-video cycle to the ADV7513 bus.
module hdmi_pix_fetch #(
  parameter int unsigned       ADDR_W          = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR       = '0,
  parameter int unsigned       FRAME_PIXELS    = 307200,
  parameter int unsigned       FIFO_DEPTH      = 16,
  parameter int unsigned       PREFETCH_LVL    = 8,
  parameter logic [23:0]       UNDERFLOW_COLOR = 24'h000000
) (
  input  logic              clk_25_2m,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              de_in,
  input  logic              rd_rdy,
  input  logic              rd_data_valid,
  input  logic [31:0]       rd_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [23:0]       pix_data,
  output logic              de_out,
  output logic              underflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TOT_W = CNT_W + 1;
  localparam int unsigned ISS_W = $clog2(FRAME_PIXELS + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_PREFETCH = 2'd2,
    S_STREAM   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [23:0]       r_pix;
  logic              r_de;
  logic              r_uf;
  logic [23:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_outst;
  logic [ISS_W-1:0]  r_issued;

  logic              w_dv_ok;
  logic              w_push;
  logic              w_pop;
  logic              w_issue;
  logic              w_clr;
  logic              w_underrun;
  logic [TOT_W-1:0]  w_total;
  logic              w_unused;

  assign w_unused = ^rd_data[31:24];
  assign w_total  = TOT_W'(r_count) + TOT_W'(r_outst);

  // State register
  always_ff @(posedge clk_25_2m) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state, FIFO strobes and read-issue decision
  always_comb begin
    w_next     = r_state;
    w_dv_ok    = rd_data_valid && (r_outst != '0);
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_issue    = 1'b0;
    w_clr      = 1'b0;
    w_underrun = 1'b0;
    case (r_state)
      S_IDLE: ;
      S_FLUSH: begin
        if (r_outst == '0) begin
          w_clr  = 1'b1;
          w_next = S_PREFETCH;
        end
      end
      S_PREFETCH: begin
        w_push = w_dv_ok;
        if (r_count >= CNT_W'(PREFETCH_LVL)) w_next = S_STREAM;
      end
      S_STREAM: begin
        w_push     = w_dv_ok;
        w_pop      = de_in && (r_count != '0);
        w_underrun = de_in && (r_count == '0);
      end
      default: w_next = S_IDLE;
    endcase
    // Credit counts in-flight reads and this cycle's pop; push and outstanding cancel
    if ((r_state == S_PREFETCH || r_state == S_STREAM) && !frame_start) begin
      w_issue = rd_rdy && (r_issued < ISS_W'(FRAME_PIXELS)) &&
                ((w_total - TOT_W'(w_pop)) < TOT_W'(FIFO_DEPTH));
    end
    if (frame_start) begin
      w_next = S_FLUSH;
      w_clr  = 1'b0;
    end
  end

  // Read request port and per-frame request accounting
  always_ff @(posedge clk_25_2m) begin
    if (!reset) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= BASE_ADDR;
      r_issued  <= '0;
      r_outst   <= '0;
    end else begin
      r_rd_en <= w_issue;
      if (w_clr) begin
        r_rd_addr <= BASE_ADDR;
        r_issued  <= '0;
      end else begin
        if (w_issue) r_issued <= r_issued + ISS_W'(1);
        // Address parks on the last pixel once the frame is fully requested
        if (r_rd_en && (r_issued < ISS_W'(FRAME_PIXELS)))
          r_rd_addr <= r_rd_addr + ADDR_W'(1);
      end
      case ({w_issue, w_dv_ok})
        2'b10:   r_outst <= r_outst + CNT_W'(1);
        2'b01:   r_outst <= r_outst - CNT_W'(1);
        default: r_outst <= r_outst;
      endcase
    end
  end

  // Pixel FIFO storage
  always_ff @(posedge clk_25_2m) begin
    if (w_push) r_mem[r_wr_ptr] <= rd_data[23:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_25_2m) begin
    if (!reset || w_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Pixel output stage, one cycle behind de_in
  always_ff @(posedge clk_25_2m) begin
    if (!reset) begin
      r_pix <= UNDERFLOW_COLOR;
      r_de  <= 1'b0;
      r_uf  <= 1'b0;
    end else begin
      r_de  <= de_in;
      r_pix <= w_pop ? r_mem[r_rd_ptr] : UNDERFLOW_COLOR;
      if (frame_start)     r_uf <= 1'b0;
      else if (w_underrun) r_uf <= 1'b1;
    end
  end

  assign rd_en     = r_rd_en;
  assign rd_addr   = r_rd_addr;
  assign pix_data  = r_pix;
  assign de_out    = r_de;
  assign underflow = r_uf;

endmodule

// File: tb/tb_hdmi_pix_fetch.sv
// Directed bench for hdmi_pix_fetch: in-order memory model with fixed latency
// and hold control; pixel values tagged per frame to expose stale data.
module tb_hdmi_pix_fetch;

  localparam int unsigned FP  = 48;
  localparam logic [23:0] UFC = 24'hABCDEF;

  logic        clk_25_2m   = 1'b0;
  logic        reset       = 1'b0;
  logic        frame_start = 1'b0;
  logic        de_in       = 1'b0;
  logic        rd_rdy      = 1'b0;
  logic        rd_data_valid;
  logic [31:0] rd_data;
  logic        rd_en;
  logic [23:0] rd_addr;
  logic [23:0] pix_data;
  logic        de_out;
  logic        underflow;

  logic        rnd_mode = 1'b1;
  logic        rnd_dv   = 1'b0;
  logic [31:0] rnd_data = '0;
  logic        mem_dv   = 1'b0;
  logic [31:0] mem_data = '0;
  logic        mem_hold = 1'b0;
  logic [7:0]  mem_tag  = '0;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          frame_id = 0;
  int          seen_id = 0;
  int          n_rd_frame = 0;
  int          exp_addr = 0;
  logic [23:0] last_addr = '0;
  logic [23:0] req_q[$];
  int          req_t[$];

  assign rd_data_valid = rnd_mode ? rnd_dv   : mem_dv;
  assign rd_data       = rnd_mode ? rnd_data : mem_data;

  hdmi_pix_fetch #(
    .ADDR_W          (24),
    .BASE_ADDR       (24'h0),
    .FRAME_PIXELS    (FP),
    .FIFO_DEPTH      (16),
    .PREFETCH_LVL    (8),
    .UNDERFLOW_COLOR (UFC)
  ) u_dut (
    .clk_25_2m     (clk_25_2m),
    .reset         (reset),
    .frame_start   (frame_start),
    .de_in         (de_in),
    .rd_rdy        (rd_rdy),
    .rd_data_valid (rd_data_valid),
    .rd_data       (rd_data),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .pix_data      (pix_data),
    .de_out        (de_out),
    .underflow     (underflow)
  );

  always #5 clk_25_2m = ~clk_25_2m;

  always @(posedge clk_25_2m) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_25_2m);
    #1;
  endtask

  // Request monitor plus in-order memory returning data 3+ cycles after rd_en
  always @(negedge clk_25_2m) begin
    if (frame_id != seen_id) begin
      seen_id    = frame_id;
      n_rd_frame = 0;
      exp_addr   = 0;
    end
    if (rd_en === 1'b1) begin
      check_eq("rd_addr_seq", 32'(rd_addr), 32'(exp_addr));
      exp_addr++;
      n_rd_frame++;
      last_addr = rd_addr;
      req_q.push_back({mem_tag, rd_addr[15:0]});
      req_t.push_back(cyc);
    end
    mem_dv = 1'b0;
    if (!mem_hold && req_q.size() > 0 && (cyc - req_t[0]) >= 3) begin
      mem_dv   = 1'b1;
      mem_data = {8'hA5, req_q[0]};
      void'(req_q.pop_front());
      void'(req_t.pop_front());
    end
  end

  initial begin
    // Reset with random inputs
    repeat (3) begin
      frame_start = 1'($urandom_range(0, 1));
      de_in       = 1'($urandom_range(0, 1));
      rd_rdy      = 1'($urandom_range(0, 1));
      rnd_dv      = 1'($urandom_range(0, 1));
      rnd_data    = $urandom;
      step();
    end
    check_eq("rst_rd_en", 32'(rd_en), 32'(0));
    check_eq("rst_rd_addr", 32'(rd_addr), 32'(0));
    check_eq("rst_pix", 32'(pix_data), 32'(UFC));
    check_eq("rst_de_out", 32'(de_out), 32'(0));
    check_eq("rst_underflow", 32'(underflow), 32'(0));
    frame_start = 1'b0; de_in = 1'b0; rd_rdy = 1'b0; rnd_dv = 1'b0;
    reset = 1'b1;
    rnd_mode = 1'b0;
    repeat (2) step();
    check_eq("idle_rd_en", 32'(rd_en), 32'(0));

    // Frame 1: prefetch fills exactly the FIFO depth
    mem_tag = 8'h00; rd_rdy = 1'b1; frame_start = 1'b1; frame_id++;
    step();
    frame_start = 1'b0;
    repeat (40) step();
    check_eq("pref_count", 32'(n_rd_frame), 32'(16));
    check_eq("pref_rd_en_idle", 32'(rd_en), 32'(0));
    check_eq("pref_pix", 32'(pix_data), 32'(UFC));

    // Frame 1: stream to end of frame, then underflow
    de_in = 1'b1;
    for (int i = 0; i < 52; i++) begin
      step();
      check_eq("strm_pix", 32'(pix_data), (i < int'(FP)) ? 32'(i) : 32'(UFC));
      check_eq("strm_de_out", 32'(de_out), 32'(1));
      check_eq("strm_underflow", 32'(underflow), (i >= int'(FP)) ? 32'(1) : 32'(0));
    end
    de_in = 1'b0;
    step();
    check_eq("strm_de_off", 32'(de_out), 32'(0));
    check_eq("strm_pix_off", 32'(pix_data), 32'(UFC));
    repeat (10) step();
    check_eq("eof_count", 32'(n_rd_frame), 32'(FP));
    check_eq("eof_last_addr", 32'(last_addr), 32'(FP - 1));
    check_eq("eof_rd_addr_hold", 32'(rd_addr), 32'(FP - 1));
    check_eq("eof_uf_sticky", 32'(underflow), 32'(1));

    // Frame 2: memory stalls after prefetch
    mem_tag = 8'h01; frame_start = 1'b1; frame_id++;
    step();
    frame_start = 1'b0;
    check_eq("f2_uf_clear", 32'(underflow), 32'(0));
    repeat (40) step();
    check_eq("f2_pref_count", 32'(n_rd_frame), 32'(16));
    rd_rdy = 1'b0; de_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("uf_pix", 32'(pix_data), (i < 16) ? 32'(24'h010000 + i) : 32'(UFC));
      check_eq("uf_flag", 32'(underflow), (i >= 16) ? 32'(1) : 32'(0));
    end
    de_in = 1'b0;
    repeat (5) step();
    check_eq("uf_sticky", 32'(underflow), 32'(1));

    // Frame 3: four reads left in flight
    mem_tag = 8'h03; mem_hold = 1'b1; frame_start = 1'b1; frame_id++;
    step();
    frame_start = 1'b0;
    check_eq("f3_uf_clear", 32'(underflow), 32'(0));
    step();
    rd_rdy = 1'b1;
    repeat (4) step();
    rd_rdy = 1'b0;
    repeat (3) step();
    check_eq("f3_inflight", 32'(n_rd_frame), 32'(4));

    // Frame 4: restart must discard the in-flight data
    mem_tag = 8'h04; rd_rdy = 1'b1; frame_start = 1'b1; frame_id++;
    step();
    frame_start = 1'b0;
    repeat (6) step();
    check_eq("flush_no_reads", 32'(n_rd_frame), 32'(0));
    mem_hold = 1'b0;
    repeat (40) step();
    check_eq("f4_pref_count", 32'(n_rd_frame), 32'(16));
    de_in = 1'b1;
    step();
    check_eq("f4_pix0", 32'(pix_data), 32'(24'h040000));
    step();
    check_eq("f4_pix1", 32'(pix_data), 32'(24'h040001));
    de_in = 1'b0;
    step();
    check_eq("f4_pix_off", 32'(pix_data), 32'(UFC));
    check_eq("f4_de_off", 32'(de_out), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
